fxp_out_stream: RTL and testbench
=================================

# fxp_out_stream

Output stage placed directly downstream of the cumulative fixed-point estimation filter. It takes the filter's wide result word and its `valid` strobe, rounds and saturates each word to the narrow output width, and buffers the words in a small FIFO. A ready/valid handshake presents them to the consumer (capture logic, serializer or testbench sink), so a consumer stall never blocks the filter. Words that cannot be buffered are dropped and counted.

## Interface
- `in_w`, 24: width of the filter result (`OUT_WIDTH`), signed two's complement.
- `out_w`, 14: width of the output word, signed.
- `shift`, 8: LSBs discarded by rounding; 0 ≤ `shift` < `in_w`.
- `fifo_depth`, 8: FIFO entries; power of two, ≥ 2.
- `cnt_w`, 8: width of the drop counter.

Ports:
- `clk`  in  1: sole clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in`  in  `in_w`: filter result, qualified by `valid`.
- `valid`  in  1: single-cycle strobe; `in` is sampled on that edge.
- `out`  out  `out_w`: head-of-FIFO word (first-word fall-through).
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accept; a pop occurs when `out_valid && out_ready`.
- `level`  out  $clog2(`fifo_depth`)+1: current FIFO occupancy.
- `ovf`  out  1: sticky flag, set on the first dropped word.
- `clr_ovf`  in  1: synchronous clear of `ovf` and `drop_cnt`.
- `drop_cnt`  out  `cnt_w`: number of dropped words; saturates at all-ones.

## Operation
- Rounding is round-half-up: r = (sign-extend(`in`, `in_w`+1) + 2^(`shift`−1)) >>> `shift`. The arithmetic shift is done at `in_w`+1 bits so the addition cannot overflow. When `shift` = 0, r = `in`.
- Saturation: if r > 2^(`out_w`−1)−1, output 2^(`out_w`−1)−1. If r < −2^(`out_w`−1), output −2^(`out_w`−1). Otherwise output r truncated to `out_w`.
- Stage 1 registers the rounded word and a `s1_valid` bit on every `valid` edge. `s1_valid` clears on the next edge if `valid` is low.
- Stage 2 is the FIFO write on an edge where `s1_valid` = 1:
  - Accept if level < `fifo_depth`, or if a pop happens on the same edge.
  - Otherwise drop the word, set `ovf`, and increment `drop_cnt` (saturating).
- Pop and push on the same edge: level is unchanged and order is preserved. This holds at full and at level 1.
- When empty, `out` is driven 0 and `out_valid` = 0.
- `clr_ovf` and a drop on the same edge: the drop wins, so `ovf` = 1 and `drop_cnt` = 1.
- Pointers are `$clog2(fifo_depth)` bits and wrap naturally. Level is tracked by an explicit counter, not by pointer difference.
- No state machine beyond the FIFO. The block does not check the filter's DSR cadence: back-to-back `valid` strobes (`DSR` = 1) must sustain one word per clock with no drops when `out_ready` is held high.

## Timing
- Latency: `valid` sampled at edge k, then `out_valid` and `out` are updated after edge k+1, provided the FIFO was empty.
- Throughput is 1 word/clock in and 1 word/clock out.
- `out`, `out_valid` and `level` are registered, or decoded from registered state with no path from `out_ready`.
- Reset values: `out` = 0, `out_valid` = 0, `level` = 0, `ovf` = 0, `drop_cnt` = 0, `s1_valid` = 0. Pointers are 0.
- Reset asserted mid-operation discards the FIFO contents and the stage-1 word immediately, without waiting for a clock edge.
- `out_ready` while `out_valid` = 0 has no effect.

## Structure
- Shared package `fxp_stream_pkg`:
  - `localparam` helpers for the level width.
  - `function automatic round_sat(in, shift, out_w)`, reused by later rescaling stages.
- One sub-module, `fxp_sync_fifo` (`width`, `depth`), holding the pointers, level, memory and first-word fall-through read. The top level contains stage 1, drop logic and counters.
- The bench binds a property checker for:
  - level ≤ `fifo_depth`;
  - `out_valid` == (level != 0);
  - `drop_cnt` monotonic until `clr_ovf`.

## Test plan
- Rounding, with `in_w`=24, `out_w`=14, `shift`=8:
  - `in`=384 → `out`=2, `out_valid` high 2 edges after `valid`;
  - `in`=−128 → 0;
  - `in`=−129 → −1;
  - `in`=127 → 0.
- Saturation:
  - `in`=0x7FFFFF → `out`=8191;
  - `in`=0x800000 → `out`=−8192;
  - `in`=2,097,024 → 8191;
  - `in`=−2,097,152 → −8192.
- Overflow:
  - `out_ready`=0, 9 strobes of values 1..9 (scaled by 256) → `level`=8, `ovf`=1, `drop_cnt`=1.
  - Then `out_ready`=1 → `out` = 1..8 in order, then `out_valid`=0.
  - `clr_ovf` → `ovf`=0, `drop_cnt`=0.
- Full with simultaneous push/pop: at `level`=8, one edge with push and pop → `level` stays 8, no drop, and the ordering check passes.
- Streaming: `valid` every clock for 1000 words with `out_ready` random at 50% → outputs match the reference model, with drops accounted exactly in `drop_cnt`.
- Async reset: 5 words buffered, `rst` pulsed between edges → `out_valid`=0, `level`=0, `ovf`=0 before the next edge. The next `valid` yields its word 2 edges later.

Source files
------------

// File: rtl/fxp_stream_pkg.sv
// Shared types and helpers for the fixed-point output stream stages.
// round_sat is also used by downstream rescaling stages.
package fxp_stream_pkg;

   localparam int IN_W       = 24;
   localparam int OUT_W      = 14;
   localparam int SHIFT      = 8;
   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 8;

   function automatic int lvl_w(int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int LVL_W = lvl_w(FIFO_DEPTH);

   // Round-half-up then clamp to the signed out_w range; 64-bit headroom.
   function automatic logic signed [31:0] round_sat(
      logic signed [63:0] x,
      int                 shift,
      int                 out_w
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = x;
      if (shift > 0)
         r = (x + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (r > hi)
         r = hi;
      else if (r < lo)
         r = lo;
      return r[31:0];
   endfunction

endpackage

// File: rtl/fxp_out_stream_fifo.sv
// Synchronous FIFO with first-word fall-through read and explicit level.
// Reports a rejected push so the caller can count drops.
module fxp_sync_fifo #(
   parameter int width = 14,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [width-1:0]         wdata_i,
   output logic [width-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(depth):0]   level_o,
   output logic                     drop_o
);

   localparam int AW = $clog2(depth);

   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    wr_d;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    rd_d;
   logic [AW:0]      lvl_q;
   logic [AW:0]      lvl_d;
   logic [width-1:0] mem_q [depth];
   logic             empty;
   logic             full;
   logic             rd;
   logic             wr;

   assign empty = (lvl_q == '0);
   assign full  = (lvl_q == (AW+1)'(depth));
   assign rd    = pop_i & ~empty;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign wr    = push_i & (~full | rd);
   assign drop_o = push_i & ~wr;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (wr)
         wr_d = wr_q + AW'(1);
      if (rd)
         rd_d = rd_q + AW'(1);
      if (wr && !rd)
         lvl_d = lvl_q + (AW+1)'(1);
      else if (rd && !wr)
         lvl_d = lvl_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = empty ? '0 : mem_q[rd_q];
   assign valid_o = ~empty;
   assign level_o = lvl_q;

endmodule

// File: rtl/fxp_out_stream.sv
// Round/saturate stage feeding a small FIFO with ready/valid output.
// Words the FIFO cannot take are dropped and counted.
module fxp_out_stream
   import fxp_stream_pkg::*;
#(
   parameter int in_w       = IN_W,
   parameter int out_w      = OUT_W,
   parameter int shift      = SHIFT,
   parameter int fifo_depth = FIFO_DEPTH,
   parameter int cnt_w      = CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [in_w-1:0]               in,
   input  logic                          valid,
   output logic [out_w-1:0]              out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(fifo_depth):0]   level,
   output logic                          ovf,
   input  logic                          clr_ovf,
   output logic [cnt_w-1:0]              drop_cnt
);

   logic signed [63:0] in_ext;
   logic signed [31:0] rs;
   logic [out_w-1:0]   s1_q;
   logic [out_w-1:0]   s1_d;
   logic               s1_valid_q;
   logic               drop;
   logic               ovf_q;
   logic               ovf_d;
   logic [cnt_w-1:0]   drop_cnt_q;
   logic [cnt_w-1:0]   drop_cnt_d;

   assign in_ext = 64'(signed'(in));
   assign rs     = round_sat(in_ext, shift, out_w);
   assign s1_d   = rs[out_w-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= valid;
         if (valid)
            s1_q <= s1_d;
      end
   end

   fxp_sync_fifo #(
      .width (out_w),
      .depth (fifo_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (s1_valid_q),
      .pop_i   (out_ready),
      .wdata_i (s1_q),
      .rdata_o (out),
      .valid_o (out_valid),
      .level_o (level),
      .drop_o  (drop)
   );

   // A drop on the same edge as a clear wins: count restarts at one.
   always_comb begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (clr_ovf)
            drop_cnt_d = cnt_w'(1);
         else if (drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + cnt_w'(1);
      end else if (clr_ovf) begin
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ovf      = ovf_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fxp_out_stream.sv
// Bench for fxp_out_stream: vector table, corner sequences, and a
// randomized stream checked against a queue-based reference model.
module tb_fxp_out_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] din = '0;
   logic        valid = 1'b0;
   logic [13:0] out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  level;
   logic        ovf;
   logic        clr_ovf = 1'b0;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fxp_out_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .valid     (valid),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf),
      .drop_cnt  (drop_cnt)
   );

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Property checks on every cycle out of reset.
   bit   clr_seen = 1'b0;
   bit   rst_seen = 1'b1;
   int   prev_cnt = 0;

   always @(posedge clk) if (clr_ovf) clr_seen = 1'b1;
   always @(posedge rst) rst_seen = 1'b1;

   always @(negedge clk) begin
      if (!rst) begin
         chk("prop_level_le_depth", int'(level <= 4'd8), 1);
         chk("prop_valid_eq_nonempty", int'(out_valid),
             int'(level != 4'd0));
         if (!clr_seen && !rst_seen)
            chk("prop_drop_monotonic", int'(drop_cnt >= 8'(prev_cnt)), 1);
         prev_cnt = int'(drop_cnt);
         clr_seen = 1'b0;
         rst_seen = 1'b0;
      end
   end

   // Reference rounding from the rules using real arithmetic.
   function automatic int ref_rs(int x);
      real v;
      v = $floor((real'(x) + 128.0) / 256.0);
      if (v > 8191.0) return 8191;
      if (v < -8192.0) return -8192;
      return int'(v);
   endfunction

   typedef struct {
      int din;
      int exp;
   } vec_t;

   vec_t vec [8];

   int q [$];
   bit m_s1v;
   int m_s1;
   int m_cnt;
   bit m_ovf;

   initial begin
      vec[0] = '{384, 2};
      vec[1] = '{-128, 0};
      vec[2] = '{-129, -1};
      vec[3] = '{127, 0};
      vec[4] = '{32'h007F_FFFF, 8191};
      vec[5] = '{-8388608, -8192};
      vec[6] = '{2097024, 8191};
      vec[7] = '{-2097152, -8192};

      #2;
      chk("rst_out", int'(out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      #12 rst = 1'b0;
      tick();

      foreach (vec[i]) begin
         din = 24'(vec[i].din);
         valid = 1'b1;
         tick();
         chk("vec_lat_one_edge", int'(out_valid), 0);
         valid = 1'b0;
         tick();
         chk("vec_out_valid", int'(out_valid), 1);
         chk($sformatf("vec%0d_out", i), int'($signed(out)), vec[i].exp);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("vec_popped", int'(out_valid), 0);
      end

      // Overflow: nine strobes into an eight-entry FIFO.
      for (int k = 1; k <= 9; k++) begin
         din = 24'(k * 256);
         valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      tick();
      chk("ovf_level", int'(level), 8);
      chk("ovf_flag", int'(ovf), 1);
      chk("ovf_drop_cnt", int'(drop_cnt), 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("ovf_drain_out", int'($signed(out)), k);
         tick();
      end
      out_ready = 1'b0;
      chk("ovf_drain_empty", int'(out_valid), 0);
      chk("ovf_drain_out0", int'(out), 0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", int'(ovf), 0);
      chk("clr_drop_cnt", int'(drop_cnt), 0);

      // Full FIFO with simultaneous push and pop.
      for (int k = 11; k <= 19; k++) begin
         din = 24'(k * 256);
         valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      chk("full_level", int'(level), 8);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pushpop_level", int'(level), 8);
      chk("pushpop_drop_cnt", int'(drop_cnt), 0);
      chk("pushpop_ovf", int'(ovf), 0);
      out_ready = 1'b1;
      for (int k = 12; k <= 19; k++) begin
         chk("pushpop_order", int'($signed(out)), k);
         tick();
      end
      out_ready = 1'b0;
      chk("pushpop_empty", int'(out_valid), 0);

      // Async reset with words buffered and one in stage 1.
      for (int k = 1; k <= 6; k++) begin
         din = 24'(k * 256);
         valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      chk("ar_level_pre", int'(level), 5);
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", int'(out_valid), 0);
      chk("ar_level", int'(level), 0);
      chk("ar_ovf", int'(ovf), 0);
      rst = 1'b0;
      tick();
      chk("ar_s1_discarded", int'(out_valid), 0);
      din = 24'(7 * 256);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("ar_lat1", int'(out_valid), 0);
      tick();
      chk("ar_lat2", int'(out_valid), 1);
      chk("ar_word", int'($signed(out)), 7);

      // Randomized stream vs. reference model.
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      q.delete();
      m_s1v = 1'b0;
      m_s1  = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         int  x;
         bit  pop;
         bit  drp;
         x = $signed($urandom) >>> 8;
         if ($urandom_range(3) == 0)
            x = x >>> 10;
         din = 24'(x);
         valid = 1'b1;
         out_ready = 1'($urandom_range(1));
         clr_ovf = ($urandom_range(63) == 0);
         pop = (q.size() > 0) && out_ready;
         drp = m_s1v && !(q.size() < 8 || pop);
         if (pop)
            void'(q.pop_front());
         if (m_s1v && !drp)
            q.push_back(m_s1);
         if (drp) begin
            m_ovf = 1'b1;
            m_cnt = clr_ovf ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
         end else if (clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
         m_s1v = 1'b1;
         m_s1  = ref_rs(x);
         tick();
         chk("st_out_valid", int'(out_valid), int'(q.size() > 0));
         chk("st_out", int'($signed(out)), q.size() > 0 ? q[0] : 0);
         chk("st_level", int'(level), q.size());
         chk("st_ovf", int'(ovf), int'(m_ovf));
         chk("st_drop_cnt", int'(drop_cnt), m_cnt);
      end
      valid = 1'b0;
      clr_ovf = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();
      chk("st_drained", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
